doodle_sprite_renderer: RTL and testbench

Pixel-side consumer of the game-logic position bus. It snapshots the Doodle and Cannon position/size once per frame on the rising edge of frame_clk. For each VGA pixel (DrawX, DrawY) it decides, in a fixed 2-cycle pipeline, whether the pixel belongs to the cannon ball, the Doodle sprite (ROM-based, with transparency) or the graph-paper background, and drives 8-bit RGB to the VGA output stage. It sits between the jump/physics logic and the VGA controller.

---
 rtl/doodle_render_pkg.sv | 71 +++++++
 rtl/doodle_sprite_renderer_if.sv | 31 +++
 rtl/doodle_sprite_rom.sv | 15 +
 rtl/doodle_sprite_renderer.sv | 130 +++++++++++++
 tb/tb_doodle_sprite_renderer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/doodle_render_pkg.sv
// Shared colours, palette, game-state encoding and snapshot types for the
// Doodle pixel renderer and the jump-state logic.
package doodle_render_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'b000,
        PLAY = 3'b001,
        OVER = 3'b010
    } game_state_e;

    localparam int unsigned SPR_DIM   = 24;
    localparam int unsigned SPR_WORDS = SPR_DIM * SPR_DIM;

    localparam logic [23:0] COL_PAPER     = 24'hF8F4E8;
    localparam logic [23:0] COL_GRID      = 24'hD8E4F0;
    localparam logic [23:0] COL_OVER_BG   = 24'hF0C0C0;
    localparam logic [23:0] COL_OVER_GRID = 24'hE09090;
    localparam logic [23:0] COL_CANNON    = 24'h202020;

    // Entry 0 is never displayed: index 0 marks a transparent sprite texel.
    localparam logic [23:0] PALETTE [16] = '{
        24'h000000, 24'h1A1A1A, 24'h6BBF3A, 24'h8ED14F,
        24'h4F8F2A, 24'hD9E84A, 24'hFFFFFF, 24'h2B5F1A,
        24'hE8C547, 24'hB07A2E, 24'h5AA8E0, 24'h3C7FC0,
        24'hF29E4C, 24'hC9503C, 24'h9A9A9A, 24'h404040
    };

    typedef struct packed {
        logic [9:0] doodle_x;
        logic [9:0] doodle_y;
        logic [9:0] doodle_s;
        logic [9:0] cannon_x;
        logic [9:0] cannon_y;
        logic [9:0] cannon_s;
        logic [2:0] state;
    } snap_t;

    localparam snap_t SNAP_RESET = '{
        doodle_x: 10'd320,
        doodle_y: 10'd240,
        doodle_s: 10'd12,
        cannon_x: 10'd320,
        cannon_y: 10'd240,
        cannon_s: 10'd2,
        state:    IDLE
    };

    typedef struct packed {
        logic valid;
        logic blank;
        logic grid;
        logic over;
        logic doodle_hit;
        logic cannon_hit;
    } pix_flags_t;

    // Doodle image: 2-texel transparent border, a diagonal lattice of
    // transparent holes, the rest cycles through palette entries 1..15.
    function automatic logic [3:0] sprite_index(input logic [9:0] addr);
        int unsigned a;
        int unsigned r;
        int unsigned c;
        a = 32'(addr);
        r = a / SPR_DIM;
        c = a % SPR_DIM;
        if (a >= SPR_WORDS || r < 2 || r > 21 || c < 2 || c > 21 || ((r + c) % 5) == 0)
            return 4'h0;
        return 4'(((r * 3 + c) % 15) + 1);
    endfunction

endpackage

// File: rtl/doodle_sprite_renderer_if.sv
// Position bus from game logic plus pixel coordinates in, RGB out to the VGA stage.
interface doodle_sprite_renderer_if;

    logic       frame_clk;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic [9:0] DoodleX;
    logic [9:0] DoodleY;
    logic [9:0] DoodleS;
    logic [9:0] CannonX;
    logic [9:0] CannonY;
    logic [9:0] CannonS;
    logic [2:0] outstate;
    logic [7:0] Red;
    logic [7:0] Green;
    logic [7:0] Blue;

    modport master (
        output frame_clk, DrawX, DrawY, blank,
        output DoodleX, DoodleY, DoodleS, CannonX, CannonY, CannonS, outstate,
        input  Red, Green, Blue
    );

    modport slave (
        input  frame_clk, DrawX, DrawY, blank,
        input  DoodleX, DoodleY, DoodleS, CannonX, CannonY, CannonS, outstate,
        output Red, Green, Blue
    );

endinterface

// File: rtl/doodle_sprite_rom.sv
// 576x4 synchronous sprite ROM holding Doodle palette indices, one-cycle read.
module doodle_sprite_rom
    import doodle_render_pkg::*;
(
    input  logic       Clk,
    input  logic [9:0] addr,
    output logic [3:0] data
);

    // Contents come from sprite_index() so the image needs no external hex file.
    always_ff @(posedge Clk) begin
        data <= sprite_index(addr);
    end

endmodule

// File: rtl/doodle_sprite_renderer.sv
// Per-pixel renderer: frame snapshot of positions, hit test, sprite ROM read
// and priority colour mux in a fixed 2-cycle pipeline.
module doodle_sprite_renderer
    import doodle_render_pkg::*;
#(
    parameter int unsigned SPR_W   = 24,
    parameter int unsigned BG_GRID = 4
) (
    input logic                     Clk,
    input logic                     Reset,
    doodle_sprite_renderer_if.slave bus
);

    snap_t       snap_q, snap_d;
    logic        fc_q;
    logic        rise_q;
    logic        v0_q;
    pix_flags_t  s1_q, s1_d;
    logic [9:0]  rom_addr_d;
    logic [3:0]  rom_idx;
    logic [23:0] rgb_q, rgb_d;

    logic signed [11:0] org_x, org_y, dx, dy, span;
    logic signed [10:0] ex, ey;
    logic [9:0]         ex_abs, ey_abs;
    logic [21:0]        dist2, rad2;
    logic               doodle_hit, cannon_hit;

    // Frame snapshot. fc_q resets high so a frame_clk held high across reset
    // release is not mistaken for a fresh rising edge.
    always_comb begin
        snap_d = snap_q;
        if (rise_q) begin
            snap_d.doodle_x = bus.DoodleX;
            snap_d.doodle_y = bus.DoodleY;
            snap_d.doodle_s = bus.DoodleS;
            snap_d.cannon_x = bus.CannonX;
            snap_d.cannon_y = bus.CannonY;
            snap_d.cannon_s = bus.CannonS;
            snap_d.state    = bus.outstate;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fc_q   <= 1'b1;
            rise_q <= 1'b0;
            snap_q <= SNAP_RESET;
        end else begin
            fc_q   <= bus.frame_clk;
            rise_q <= bus.frame_clk & ~fc_q;
            snap_q <= snap_d;
        end
    end

    // Stage 0: hit test against the shadowed positions.
    always_comb begin
        org_x = $signed({2'b00, snap_q.doodle_x}) - $signed({2'b00, snap_q.doodle_s});
        org_y = $signed({2'b00, snap_q.doodle_y}) - $signed({2'b00, snap_q.doodle_s});
        dx    = $signed({2'b00, bus.DrawX}) - org_x;
        dy    = $signed({2'b00, bus.DrawY}) - org_y;
        span  = $signed({1'b0, snap_q.doodle_s, 1'b0});

        doodle_hit = (dx >= 12'sd0) && (dx < span) && (dy >= 12'sd0) && (dy < span);

        ex     = $signed({1'b0, bus.DrawX}) - $signed({1'b0, snap_q.cannon_x});
        ey     = $signed({1'b0, bus.DrawY}) - $signed({1'b0, snap_q.cannon_y});
        ex_abs = ex[10] ? 10'(-ex) : ex[9:0];
        ey_abs = ey[10] ? 10'(-ey) : ey[9:0];
        dist2  = 22'(ex_abs) * 22'(ex_abs) + 22'(ey_abs) * 22'(ey_abs);
        rad2   = 22'(snap_q.cannon_s) * 22'(snap_q.cannon_s);

        cannon_hit = (dist2 <= rad2);

        rom_addr_d = doodle_hit ? 10'(32'(dy[9:0]) * SPR_W + 32'(dx[9:0])) : '0;

        s1_d            = '0;
        s1_d.valid      = v0_q;
        s1_d.blank      = bus.blank;
        s1_d.grid       = (bus.DrawX[BG_GRID-1:0] == '0) || (bus.DrawY[BG_GRID-1:0] == '0);
        s1_d.over       = (snap_q.state == OVER);
        s1_d.doodle_hit = doodle_hit;
        s1_d.cannon_hit = cannon_hit;
    end

    // Stage 1: ROM lookup with the per-pixel flags travelling alongside.
    // v0_q holds the first post-reset pixel invalid so the pipe refills cleanly.
    doodle_sprite_rom u_rom (
        .Clk  (Clk),
        .addr (rom_addr_d),
        .data (rom_idx)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            v0_q <= 1'b0;
            s1_q <= '0;
        end else begin
            v0_q <= 1'b1;
            s1_q <= s1_d;
        end
    end

    // Stage 2: priority mux, cannon over sprite over background.
    always_comb begin
        rgb_d = '0;
        if (s1_q.valid && s1_q.blank) begin
            if (s1_q.cannon_hit)
                rgb_d = COL_CANNON;
            else if (s1_q.doodle_hit && rom_idx != 4'h0)
                rgb_d = PALETTE[rom_idx];
            else if (s1_q.over)
                rgb_d = s1_q.grid ? COL_OVER_GRID : COL_OVER_BG;
            else
                rgb_d = s1_q.grid ? COL_GRID : COL_PAPER;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            rgb_q <= '0;
        else
            rgb_q <= rgb_d;
    end

    assign bus.Red   = rgb_q[23:16];
    assign bus.Green = rgb_q[15:8];
    assign bus.Blue  = rgb_q[7:0];

endmodule

// File: tb/tb_doodle_sprite_renderer.sv
// Self-checking bench for doodle_sprite_renderer: directed scenarios followed by
// randomized pixels/positions, all compared against a behavioural model.
module tb_doodle_sprite_renderer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    doodle_sprite_renderer_if bus ();

    doodle_sprite_renderer #(
        .SPR_W   (24),
        .BG_GRID (4)
    ) u_dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        bit rst;
        bit fc;
        bit blank;
        int x;
        int y;
        int ddx;
        int ddy;
        int dds;
        int cx;
        int cy;
        int cs;
        int st;
    } vec_t;

    typedef struct {
        int ddx;
        int ddy;
        int dds;
        int cx;
        int cy;
        int cs;
        int st;
    } shadow_t;

    localparam logic [23:0] REF_PAL [16] = '{
        24'h000000, 24'h1A1A1A, 24'h6BBF3A, 24'h8ED14F,
        24'h4F8F2A, 24'hD9E84A, 24'hFFFFFF, 24'h2B5F1A,
        24'hE8C547, 24'hB07A2E, 24'h5AA8E0, 24'h3C7FC0,
        24'hF29E4C, 24'hC9503C, 24'h9A9A9A, 24'h404040
    };

    int          n_checks = 0;
    int          n_pass   = 0;
    shadow_t     sh;
    shadow_t     sh_default;
    bit          fc_prev  = 1'b1;
    bit          pend     = 1'b0;
    bit          prev_rst = 1'b0;
    logic [23:0] exp_rgb_q[$];
    string       exp_tag_q[$];
    vec_t        v;

    task automatic check_rgb(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    endtask

    // Reference sprite image, by texel row/column.
    function automatic int ref_idx(input int r, input int c);
        if (r < 2 || r > 21 || c < 2 || c > 21) return 0;
        if ((r + c) % 5 == 0) return 0;
        return ((3 * r + c) % 15) + 1;
    endfunction

    function automatic logic [23:0] ref_pixel(input vec_t p, input shadow_t s);
        int  dx, dy, w, i;
        bit  grid;
        if (!p.blank) return 24'h000000;
        if ((p.x - s.cx) * (p.x - s.cx) + (p.y - s.cy) * (p.y - s.cy) <= s.cs * s.cs)
            return 24'h202020;
        dx = p.x - (s.ddx - s.dds);
        dy = p.y - (s.ddy - s.dds);
        w  = 2 * s.dds;
        if (dx >= 0 && dx < w && dy >= 0 && dy < w) begin
            i = ref_idx(dy, dx);
            if (i != 0) return REF_PAL[i];
        end
        grid = (p.x % 16 == 0) || (p.y % 16 == 0);
        if (s.st == 2) return grid ? 24'hE09090 : 24'hF0C0C0;
        return grid ? 24'hD8E4F0 : 24'hF8F4E8;
    endfunction

    // One clock: check the pixel driven two cycles ago, drive this cycle's
    // inputs, predict their colour and advance the snapshot model.
    task automatic step(input string tag);
        logic [23:0] e;
        @(posedge clk);
        #1;
        if (exp_rgb_q.size() == 2)
            check_rgb(exp_tag_q.pop_front(), {bus.Red, bus.Green, bus.Blue}, exp_rgb_q.pop_front());

        rst           = v.rst;
        bus.frame_clk = v.fc;
        bus.blank     = v.blank;
        bus.DrawX     = 10'(v.x);
        bus.DrawY     = 10'(v.y);
        bus.DoodleX   = 10'(v.ddx);
        bus.DoodleY   = 10'(v.ddy);
        bus.DoodleS   = 10'(v.dds);
        bus.CannonX   = 10'(v.cx);
        bus.CannonY   = 10'(v.cy);
        bus.CannonS   = 10'(v.cs);
        bus.outstate  = 3'(v.st);

        e = (v.rst || prev_rst) ? 24'h000000 : ref_pixel(v, sh);
        if (v.rst && exp_rgb_q.size() > 0) begin
            void'(exp_rgb_q.pop_back());
            exp_rgb_q.push_back(24'h000000);
        end
        exp_rgb_q.push_back(e);
        exp_tag_q.push_back(tag);
        prev_rst = v.rst;

        if (v.rst) begin
            sh      = sh_default;
            fc_prev = 1'b1;
            pend    = 1'b0;
        end else begin
            if (pend) sh = '{v.ddx, v.ddy, v.dds, v.cx, v.cy, v.cs, v.st};
            pend    = v.fc && !fc_prev;
            fc_prev = v.fc;
        end
    endtask

    task automatic px(input int x, input int y, input string tag);
        v.x = x;
        v.y = y;
        step(tag);
    endtask

    task automatic snap(input string tag);
        v.fc = 1'b0;
        step(tag);
        v.fc = 1'b1;
        step(tag);
        step(tag);
    endtask

    function automatic int near(input int c, input int span);
        return (c + int'($urandom_range(0, 2 * span)) - span) & 1023;
    endfunction

    initial begin
        sh_default = '{320, 240, 12, 320, 240, 2, 0};
        sh         = sh_default;
        v = '{rst: 1'b1, fc: 1'b0, blank: 1'b1, x: 0, y: 0, ddx: 320, ddy: 240,
              dds: 12, cx: 320, cy: 240, cs: 2, st: 0};

        repeat (2) step("reset_black");
        v.rst = 1'b0;

        px(5, 7, "paper_default");
        px(16, 7, "grid_x");
        px(5, 16, "grid_y");
        px(320, 240, "cannon_over_doodle");
        px(308, 228, "sprite_addr0_transparent");
        px(312, 230, "sprite_opaque");
        px(322, 240, "cannon_rim");
        px(323, 240, "sprite_beside_cannon");

        v.ddx = 5;
        snap("snap_left");
        px(0, 240, "left_edge_no_wrap");
        px(1, 230, "left_edge_row2");
        px(1000, 240, "far_right_miss");
        px(1023, 241, "far_right_miss2");

        v.ddx = 320;
        snap("snap_back");
        v.ddx = 400;
        v.cx  = 900;
        repeat (3) px(400, 240, "midframe_no_tear");
        v.fc = 1'b0;
        step("fc_low");
        v.fc = 1'b1;
        step("fc_rise");
        step("fc_detect");
        px(400, 240, "after_snapshot");
        px(320, 240, "old_cannon_gone");

        v.st = 2;
        snap("snap_over");
        px(5, 7, "over_bg");
        px(16, 7, "over_grid");
        px(400, 240, "over_sprite");
        v.blank = 1'b0;
        px(5, 7, "blanked");
        v.blank = 1'b1;

        v.st = 0;
        snap("snap_play");
        for (int i = 0; i < 10; i++) begin
            v.rst = (i == 4);
            px(392 + i, 236 + i, "reset_midstream");
        end
        v.rst = 1'b0;
        repeat (3) px(400, 240, "reset_shadow_default");
        px(320, 240, "reset_cannon_default");
        v.fc = 1'b0;
        step("rearm_low");
        v.fc = 1'b1;
        step("rearm_rise");
        step("rearm_detect");
        px(400, 240, "rearm_snapshot");

        for (int i = 0; i < 3000; i++) begin
            v.rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) v.fc = ~v.fc;
            if ($urandom_range(0, 59) == 0) begin
                v.ddx = int'($urandom_range(0, 639));
                v.ddy = int'($urandom_range(0, 479));
                v.cx  = $urandom_range(0, 1) ? near(v.ddx, 20) : int'($urandom_range(0, 1023));
                v.cy  = $urandom_range(0, 1) ? near(v.ddy, 20) : int'($urandom_range(0, 1023));
                v.cs  = int'($urandom_range(0, 20));
                v.st  = int'($urandom_range(0, 7));
            end
            v.blank = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) != 0) begin
                v.x = near(sh.ddx, 20);
                v.y = near(sh.ddy, 20);
            end else begin
                v.x = int'($urandom_range(0, 1023));
                v.y = int'($urandom_range(0, 1023));
            end
            step("random");
        end

        v.rst = 1'b0;
        repeat (2) step("drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
